tx_sig_pilot_subcarrier_map: RTL
================================

TX_SIG_PILOT_SUBCARRIER_MAP -- requirements
Module: tx_sig_pilot_subcarrier_map

Interface
REQ-001 SHALL have parameter PILOT_AMP, default 16384, the pilot magnitude as a signed 16-bit value (+1.0 in Q2.14).
REQ-002 SHALL have port clk_Modulation  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port pkt_start  input  1  one-cycle pulse that restarts the pilot polarity sequence at p0.
REQ-005 SHALL have port tx_mod_valid  input  1  the input modulated data symbol is valid.
REQ-006 SHALL have port tx_mod_ready  output  1  the block accepts an input beat this cycle.
REQ-007 SHALL have port tx_mod_re / tx_mod_im  input  16 each  signed data subcarrier value (Q2.14).
REQ-008 SHALL have port tx_freqd_to_timed_valid  output  1  the mapped subcarrier stream is valid.
REQ-009 SHALL have port tx_freqd_to_timed_re / tx_freqd_to_timed_im  output  32 each  signed mapped subcarrier value.
REQ-010 SHALL have port tx_sym_done  output  1  one-cycle pulse on the last output beat of a symbol.

Function
REQ-011 SHALL implement two states: FILL (collect 48 data beats) and EMIT (52 output beats); state after reset is FILL with fill count 0.
REQ-012 SHALL drive tx_mod_ready = 1 only in FILL with reset deasserted; a beat is accepted when tx_mod_valid and tx_mod_ready are both 1.
REQ-013 SHALL store accepted beats in a 48-entry buffer in arrival order, indices d = 0..47; gaps in tx_mod_valid SHALL be tolerated with no loss.
REQ-014 SHALL ignore tx_mod_valid while tx_mod_ready = 0; those values are never stored.
REQ-015 SHALL enter EMIT on the cycle after the 48th accepted beat, with output beat k = 0 registered on that cycle.
REQ-016 SHALL assert tx_freqd_to_timed_valid for exactly 52 contiguous cycles per symbol, k = 0..51.
REQ-017 SHALL map k to subcarriers: k = 0..25 carry -26..-1 and k = 26..51 carry +1..+26; DC is never output.
REQ-018 SHALL place pilots at k = 5 (-21), 19 (-7), 32 (+7) and 46 (+21), and place data d = 0..47 in increasing k at all other positions.
REQ-019 SHALL set each pilot value to base x p_n x PILOT_AMP, imaginary part 0.
 - base = +1 at -21, -7 and +7; base = -1 at +21.
REQ-020 SHALL generate p_n with a 7-bit LFSR, x^7 + x^4 + 1, initialised to all ones; output bit 0 -> +1, 1 -> -1.
 - Sequence begins +1,+1,+1,+1,-1,-1,-1,+1.
 - Period 127, so symbol 127 reuses p0.
REQ-021 SHALL advance the polarity LFSR once per symbol, on the cycle of k = 51.
REQ-022 SHALL sign-extend the 16-bit data and pilot values to 32 bits on output; no scaling and no saturation.
REQ-023 SHALL drive tx_freqd_to_timed_re/im to 0 whenever tx_freqd_to_timed_valid = 0.
REQ-024 SHALL pulse tx_sym_done together with beat k = 51.
REQ-025 SHALL return to FILL on the cycle after k = 51, with tx_mod_ready = 1 in that cycle.
REQ-026 SHALL act on pkt_start only in FILL with fill count 0; it then reloads the LFSR to all ones, and it is ignored at all other times.
REQ-027 SHALL, when pkt_start and an accepted beat occur in the same cycle, reload the LFSR and also store the beat as d = 0.

Reset
REQ-028 SHALL, while reset = 0, force state FILL, fill count 0, k = 0 and LFSR all ones.
REQ-029 SHALL, while reset = 0, force tx_mod_ready = 0, tx_freqd_to_timed_valid = 0, tx_freqd_to_timed_re/im = 0 and tx_sym_done = 0; buffer contents need not be cleared.
REQ-030 SHALL, on reset asserted mid-EMIT, drop tx_freqd_to_timed_valid at the next edge and discard the partial symbol.

Verification
REQ-031 SHALL cover ordering: pkt_start, then 48 contiguous beats with re = d+1, im = 0.
 - Expect k0..4 re = 1..5, k5 re = 16384.
 - Expect k6 re = 6, k19 re = 16384, k20 re = 19, k32 re = 16384.
 - Expect k46 re = -16384 (0xFFFFC000), k51 re = 48.
REQ-032 SHALL cover polarity: the 5th symbol after pkt_start (p4 = -1) has pilots -16384, -16384, -16384, +16384; symbol 128 (p127) equals symbol 1.
REQ-033 SHALL cover gapped input: tx_mod_valid every third cycle.
 - Expect valid high for exactly 52 contiguous cycles, starting 1 cycle after the 48th accept.
 - Expect tx_mod_ready = 0 for those 52 cycles.
REQ-034 SHALL cover backpressure: tx_mod_valid held at 1 during EMIT with changing data; no extra beats are stored and the next symbol starts at the first beat after ready rises.
REQ-035 SHALL cover reset mid-EMIT at k = 20.
 - Expect valid = 0 and outputs 0 at the next edge.
 - After release, expect ready = 1 and the next symbol to use p0 pilots.
REQ-036 SHALL cover sign extension: data re = 0x8000, im = 0xFFFF -> out re = 0xFFFF8000, im = 0xFFFFFFFF.

Source files
------------

// File: rtl/tx_sig_pilot_subcarrier_map_if.sv
// rtl/tx_sig_pilot_subcarrier_map_if.sv - modulated-symbol input stream and mapped-subcarrier output stream
interface tx_sig_pilot_subcarrier_map_if;
    logic               tx_mod_valid;
    logic               tx_mod_ready;
    logic signed [15:0] tx_mod_re;
    logic signed [15:0] tx_mod_im;
    logic               tx_freqd_to_timed_valid;
    logic signed [31:0] tx_freqd_to_timed_re;
    logic signed [31:0] tx_freqd_to_timed_im;
    logic               tx_sym_done;

    modport slave (
        input  tx_mod_valid, tx_mod_re, tx_mod_im,
        output tx_mod_ready, tx_freqd_to_timed_valid, tx_freqd_to_timed_re,
               tx_freqd_to_timed_im, tx_sym_done
    );

    modport master (
        output tx_mod_valid, tx_mod_re, tx_mod_im,
        input  tx_mod_ready, tx_freqd_to_timed_valid, tx_freqd_to_timed_re,
               tx_freqd_to_timed_im, tx_sym_done
    );
endinterface

// File: rtl/tx_sig_pilot_subcarrier_map.sv
// rtl/tx_sig_pilot_subcarrier_map.sv - collects 48 data beats, emits 52 subcarriers with 4 scrambled pilots
module tx_sig_pilot_subcarrier_map #(
    parameter logic signed [15:0] PILOT_AMP = 16'sd16384
) (
    input  logic clk_Modulation,
    input  logic reset,
    input  logic pkt_start,
    tx_sig_pilot_subcarrier_map_if.slave bus
);

    typedef enum logic {FILL, EMIT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [5:0]         fill_cnt;
    logic [5:0]         k;
    logic [6:0]         lfsr;
    logic [5:0]         data_idx;
    logic               accept;
    logic               last_fill;
    logic               last_beat;
    logic               is_pilot;
    logic               pilot_neg;
    logic signed [15:0] pilot_val;
    logic signed [15:0] sel_re;
    logic signed [15:0] sel_im;
    logic signed [15:0] mem_re [48];
    logic signed [15:0] mem_im [48];

    assign accept    = bus.tx_mod_valid && reset && (state == FILL);
    assign last_fill = accept && (fill_cnt == 6'd47);
    assign last_beat = (state == EMIT) && (k == 6'd51);

    always_ff @(posedge clk_Modulation) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (last_fill) state_nxt = EMIT;
            EMIT:    if (k == 6'd51) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Polarity register holds x1..x7 in bits 0..6; its feedback bit is this symbol's polarity.
    always_ff @(posedge clk_Modulation) begin
        if (!reset) begin
            fill_cnt <= 6'd0;
            k        <= 6'd0;
            lfsr     <= 7'h7f;
        end else begin
            if (accept) begin
                fill_cnt <= last_fill ? 6'd0 : fill_cnt + 6'd1;
            end
            if (state == EMIT) begin
                k <= last_beat ? 6'd0 : k + 6'd1;
            end
            if ((state == FILL) && (fill_cnt == 6'd0) && pkt_start) begin
                lfsr <= 7'h7f;
            end else if (last_beat) begin
                lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
            end
        end
    end

    always_ff @(posedge clk_Modulation) begin
        if (accept) begin
            mem_re[fill_cnt] <= bus.tx_mod_re;
            mem_im[fill_cnt] <= bus.tx_mod_im;
        end
    end

    // Data index skips the pilot slots that precede the current output beat.
    always_comb begin
        data_idx = k;
        if (k > 6'd46) begin
            data_idx = k - 6'd4;
        end else if (k > 6'd32) begin
            data_idx = k - 6'd3;
        end else if (k > 6'd19) begin
            data_idx = k - 6'd2;
        end else if (k > 6'd5) begin
            data_idx = k - 6'd1;
        end
    end

    assign is_pilot  = (k == 6'd5) || (k == 6'd19) || (k == 6'd32) || (k == 6'd46);
    assign pilot_neg = (k == 6'd46) ^ (lfsr[6] ^ lfsr[3]);
    assign pilot_val = pilot_neg ? -PILOT_AMP : PILOT_AMP;
    assign sel_re    = is_pilot ? pilot_val : mem_re[data_idx];
    assign sel_im    = is_pilot ? 16'sd0 : mem_im[data_idx];

    always_comb begin
        bus.tx_mod_ready            = reset && (state == FILL);
        bus.tx_freqd_to_timed_valid = 1'b0;
        bus.tx_freqd_to_timed_re    = 32'sd0;
        bus.tx_freqd_to_timed_im    = 32'sd0;
        bus.tx_sym_done             = 1'b0;
        if (reset && (state == EMIT)) begin
            bus.tx_freqd_to_timed_valid = 1'b1;
            bus.tx_freqd_to_timed_re    = {{16{sel_re[15]}}, sel_re};
            bus.tx_freqd_to_timed_im    = {{16{sel_im[15]}}, sel_im};
            bus.tx_sym_done             = (k == 6'd51);
        end
    end

endmodule
